serial_word_rx: RTL and testbench

SERIAL_WORD_RX -- requirements
Module: serial_word_rx

---
 rtl/serial_word_rx.sv | 134 +++++++++++++
 tb/tb_serial_word_rx.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_rx.sv
// Serial frame receiver: start bit, N data bits MSB first, even parity, stop bit.
// A good frame is handed to a one-word valid/ready output buffer one clock after its stop bit.

module serial_word_rx #(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         sin,
   output logic [N-1:0] dout,
   output logic         valid,
   input  logic         ready,
   output logic         par_err,
   output logic         frm_err,
   output logic         overrun,
   output logic         busy
);

   localparam int unsigned CntW = (N > 2) ? $clog2(N) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

   if (N < 2) begin : g_bad_width
      $error("serial_word_rx: N must be at least 2");
   end

   typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

   state_e          st_q, st_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [N-1:0]    shift_q, shift_d;
   logic            par_q, par_d;
   logic            load_q, load_d;
   logic            frm_q, frm_d;
   logic [N-1:0]    dout_q, dout_d;
   logic            valid_q, valid_d;
   logic            perr_q, perr_d;
   logic            ovr_q, ovr_d;

   // Frame FSM: advances only on bit strobes.
   always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      par_d   = par_q;
      load_d  = 1'b0;
      frm_d   = 1'b0;
      if (en) begin
         unique case (st_q)
            StIdle: begin
               if (!sin) begin
                  st_d  = StData;
                  cnt_d = '0;
               end
            end
            StData: begin
               shift_d = {shift_q[N-2:0], sin};
               if (cnt_q == CntLast) begin
                  st_d = StParity;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StParity: begin
               par_d = sin;
               st_d  = StStop;
            end
            StStop: begin
               st_d = StIdle;
               if (sin) begin
                  load_d = 1'b1;
               end else begin
                  frm_d = 1'b1;
               end
            end
            default: st_d = StIdle;
         endcase
      end
   end

   // Output buffer. shift_q/par_q are still intact on the load cycle: the earliest
   // next data bit is two strobes after the stop bit.
   always_comb begin
      dout_d  = dout_q;
      valid_d = valid_q;
      perr_d  = perr_q;
      ovr_d   = ovr_q;
      if (load_q) begin
         if (!valid_q || ready) begin
            dout_d  = shift_q;
            perr_d  = ^{shift_q, par_q};
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         st_q    <= StIdle;
         cnt_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         load_q  <= 1'b0;
         frm_q   <= 1'b0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         load_q  <= load_d;
         frm_q   <= frm_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign dout    = dout_q;
   assign valid   = valid_q;
   assign par_err = perr_q;
   assign frm_err = frm_q;
   assign overrun = ovr_q;
   assign busy    = (st_q != StIdle);

endmodule

// File: tb/tb_serial_word_rx.sv
// Self-checking bench for serial_word_rx: directed scenarios plus randomized frames
// checked against a frame-level reference model.

module tb_serial_word_rx;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         en = 1'b0;
   logic         sin = 1'b1;
   logic         ready = 1'b0;
   logic [N-1:0] dout;
   logic         valid, par_err, frm_err, overrun, busy;

   serial_word_rx #(.N(N)) dut (
      .clk(clk), .rst(rst), .en(en), .sin(sin), .dout(dout), .valid(valid),
      .ready(ready), .par_err(par_err), .frm_err(frm_err), .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: collects the sampled bits of the frame in progress and
   // judges the whole frame once start + N + parity + stop bits are in.
   bit           m_bits[$];
   logic [N-1:0] m_dout = '0, m_pword = '0;
   logic         m_valid = 0, m_perr = 0, m_frm = 0, m_ovr = 0, m_pend = 0, m_pperr = 0;
   int           m_frm_total = 0;

   int  dut_frm = 0;
   int  cyc_mismatch = 0;
   bit  rand_ready = 0;
   bit  cap_en = 0;
   logic [N:0] got_q[$];

   always @(negedge clk)
      if (cap_en && valid === 1'b1 && ready === 1'b1) got_q.push_back({par_err, dout});

   task automatic tick();
      logic [N-1:0] w;
      if (rand_ready) ready = 1'($urandom);
      if (!rst) begin
         m_bits.delete();
         m_dout = '0; m_valid = 0; m_perr = 0; m_frm = 0; m_ovr = 0; m_pend = 0;
      end else begin
         m_frm = 0;
         if (m_pend) begin
            if (!m_valid || ready) begin
               m_dout = m_pword; m_perr = m_pperr; m_valid = 1;
            end else begin
               m_ovr = 1;
            end
            m_pend = 0;
         end else if (m_valid && ready) begin
            m_valid = 0;
         end
         if (en) begin
            if (m_bits.size() == 0) begin
               if (!sin) m_bits.push_back(1'b0);
            end else begin
               m_bits.push_back(sin);
               if (m_bits.size() == N + 3) begin
                  w = '0;
                  for (int i = 1; i <= N; i++) w = {w[N-2:0], m_bits[i]};
                  if (sin) begin
                     m_pend  = 1;
                     m_pword = w;
                     m_pperr = (($countones(w) + int'(m_bits[N+1])) % 2) == 1;
                  end else begin
                     m_frm = 1;
                     m_frm_total++;
                  end
                  m_bits.delete();
               end
            end
         end
      end
      @(posedge clk);
      #1;
      if (frm_err === 1'b1) dut_frm++;
      if ({dout, valid, par_err, frm_err, overrun, busy} !==
          {m_dout, m_valid, m_perr, m_frm, m_ovr, m_bits.size() != 0})
         cyc_mismatch++;
   endtask

   // Drives one frame; gap = number of en=0 cycles (random sin) before every strobe.
   task automatic send_frame(input logic [N-1:0] w, input logic p, input logic stop,
                             input int gap);
      logic [N+2:0] fr;
      fr = {1'b0, w, p, stop};
      for (int i = N + 2; i >= 0; i--) begin
         repeat (gap) begin
            en = 1'b0; sin = 1'($urandom); tick();
         end
         en = 1'b1; sin = fr[i]; tick();
      end
      en = 1'b0; sin = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b1; sin = 1'b0;
      tick(); tick();
      checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %b exp 0", dout); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", valid); end
      checks++; if ({par_err, frm_err, overrun, busy} !== 4'b0) begin
         errors++; $display("FAIL reset_flags: got %b exp 0000", {par_err, frm_err, overrun, busy});
      end
      rst = 1'b1; en = 1'b0; sin = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int f0;
      f0 = dut_frm; cyc_mismatch = 0; ready = 1'b0;
      send_frame(4'b1011, 1'b1, 1'b1, 0);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_valid_at_stop: got %b exp 0", valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after_stop: got %b exp 0", busy); end
      tick();
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid_latency: got %b exp 1", valid); end
      checks++; if (dout !== 4'b1011) begin errors++; $display("FAIL basic_dout: got %b exp 1011", dout); end
      checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL basic_par_err: got %b exp 0", par_err); end
      ready = 1'b1; tick(); ready = 1'b0;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_accept: got %b exp 0", valid); end
      checks++; if (dut_frm - f0 !== 0) begin errors++; $display("FAIL basic_frm_pulses: got %0d exp 0", dut_frm - f0); end
      checks++; if (cyc_mismatch !== 0) begin errors++; $display("FAIL basic_model: got %0d bad cycles exp 0", cyc_mismatch); end
   endtask

   task automatic test_parity_err();
      send_frame(4'b1011, 1'b0, 1'b1, 0);
      tick();
      checks++; if ({valid, dout} !== 5'b1_1011) begin
         errors++; $display("FAIL perr_word: got %b exp 11011", {valid, dout});
      end
      checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL perr_flag: got %b exp 1", par_err); end
      ready = 1'b1; tick(); ready = 1'b0;
   endtask

   task automatic test_frame_err();
      int f0;
      f0 = dut_frm; cyc_mismatch = 0;
      send_frame(4'b0110, 1'b0, 1'b0, 0);
      checks++; if (frm_err !== 1'b1) begin errors++; $display("FAIL ferr_pulse: got %b exp 1", frm_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_idle: got %b exp 0", busy); end
      tick();
      checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL ferr_one_cycle: got %b exp 0", frm_err); end
      checks++; if ({valid, dout} !== 5'b0_1011) begin
         errors++; $display("FAIL ferr_discard: got %b exp 01011", {valid, dout});
      end
      checks++; if (dut_frm - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d exp 1", dut_frm - f0); end
      checks++; if (cyc_mismatch !== 0) begin errors++; $display("FAIL ferr_model: got %0d bad cycles exp 0", cyc_mismatch); end
   endtask

   task automatic test_overrun();
      ready = 1'b0;
      send_frame(4'b0001, 1'b1, 1'b1, 0);
      send_frame(4'b1110, 1'b1, 1'b1, 0);
      tick();
      checks++; if ({valid, dout} !== 5'b1_0001) begin
         errors++; $display("FAIL ovr_word: got %b exp 10001", {valid, dout});
      end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b exp 1", overrun); end
      ready = 1'b1; tick(); ready = 1'b0;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_accept: got %b exp 0", valid); end
      tick();
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b exp 1", overrun); end
   endtask

   task automatic test_gaps();
      logic [N-1:0] wa, wb;
      rst = 1'b0; tick(); rst = 1'b1;
      cyc_mismatch = 0; ready = 1'b0;
      wa = N'($urandom); wb = ~wa;
      send_frame(wa, ^wa, 1'b1, 2);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL gap_valid_at_stop: got %b exp 0", valid); end
      tick();
      checks++; if ({valid, dout} !== {1'b1, wa}) begin
         errors++; $display("FAIL gap_word_a: got %b exp %b", {valid, dout}, {1'b1, wa});
      end
      send_frame(wb, ^wb, 1'b1, 2);
      ready = 1'b1; tick(); ready = 1'b0;
      checks++; if ({valid, dout, par_err} !== {1'b1, wb, 1'b0}) begin
         errors++; $display("FAIL gap_accept_and_load: got %b exp %b", {valid, dout, par_err}, {1'b1, wb, 1'b0});
      end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL gap_no_overrun: got %b exp 0", overrun); end
      tick();
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL gap_hold: got %b exp 1", valid); end
      ready = 1'b1; tick(); ready = 1'b0;
      checks++; if (cyc_mismatch !== 0) begin errors++; $display("FAIL gap_model: got %0d bad cycles exp 0", cyc_mismatch); end
   endtask

   task automatic test_reset_mid();
      ready = 1'b0;
      send_frame(4'b1010, 1'b0, 1'b1, 0);
      send_frame(4'b0101, 1'b1, 1'b1, 0);
      en = 1'b1;
      sin = 1'b0; tick();
      sin = 1'b1; tick();
      sin = 1'b0; tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy: got %b exp 1", busy); end
      rst = 1'b0; sin = 1'($urandom); tick();
      rst = 1'b1; en = 1'b0; sin = 1'b1;
      checks++; if ({dout, valid, par_err, frm_err, overrun, busy} !== '0) begin
         errors++; $display("FAIL rmid_outputs: got %b exp 0", {dout, valid, par_err, frm_err, overrun, busy});
      end
      send_frame(4'b1100, 1'b0, 1'b1, 0);
      tick();
      checks++; if ({valid, dout, par_err} !== 6'b1_1100_0) begin
         errors++; $display("FAIL rmid_next_frame: got %b exp 111000", {valid, dout, par_err});
      end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rmid_overrun: got %b exp 0", overrun); end
   endtask

   task automatic test_back_to_back();
      logic [N:0]   exp_q[$];
      logic [N-1:0] w;
      logic         p;
      cyc_mismatch = 0;
      ready = 1'b1; tick();
      got_q.delete(); cap_en = 1;
      for (int k = 0; k < 8; k++) begin
         w = N'($urandom); p = 1'($urandom);
         exp_q.push_back({(($countones(w) + int'(p)) % 2) == 1, w});
         send_frame(w, p, 1'b1, 0);
      end
      tick(); tick();
      cap_en = 0;
      checks++; if (got_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL b2b_count: got %0d exp %0d", got_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         checks++; if (got_q[k] !== exp_q[k]) begin
            errors++; $display("FAIL b2b_word%0d: got %b exp %b", k, got_q[k], exp_q[k]);
         end
      end
      checks++; if (cyc_mismatch !== 0) begin errors++; $display("FAIL b2b_model: got %0d bad cycles exp 0", cyc_mismatch); end
      ready = 1'b0;
   endtask

   task automatic test_random();
      int f0, mf0;
      cyc_mismatch = 0; f0 = dut_frm; mf0 = m_frm_total;
      rand_ready = 1;
      for (int k = 0; k < 40; k++) begin
         send_frame(N'($urandom), 1'($urandom), $urandom_range(0, 4) != 0, $urandom_range(0, 2));
         repeat ($urandom_range(0, 2)) begin
            en = 1'($urandom); sin = 1'b1; tick();
         end
      end
      rand_ready = 0; ready = 1'b0;
      tick(); tick();
      checks++; if (dut_frm - f0 !== m_frm_total - mf0) begin
         errors++; $display("FAIL rand_frm_count: got %0d exp %0d", dut_frm - f0, m_frm_total - mf0);
      end
      checks++; if (cyc_mismatch !== 0) begin errors++; $display("FAIL rand_model: got %0d bad cycles exp 0", cyc_mismatch); end
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: got no finish exp finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_parity_err();
      test_frame_err();
      test_overrun();
      test_gaps();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
